// File: rtl/motion_executor.sv
`default_nettype none
// ============================================================================
// motion_executor : applies rotate/move request pulses to an 8-way heading and
//                   X/Y position; optional wall query when WALL_CHECK_EN is set.
// Revision        : 1.0
// ============================================================================
module motion_executor #(
    parameter int POS_W    = 8,
    parameter int X_MAX    = 255,
    parameter int Y_MAX    = 255,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int COOLDOWN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rotate_sig,
    input  logic [1:0]       move_sig,
    output logic             en_left,
    output logic             en_right,
    output logic             en_forward,
    output logic             en_backward,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [2:0]       heading,
    output logic             busy,
    output logic             blocked,
    output logic             map_req,
    output logic [POS_W-1:0] map_x,
    output logic [POS_W-1:0] map_y,
    input  logic             map_ack,
    input  logic             map_wall
);
    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(COOLDOWN - 1);
    localparam logic signed [POS_W:0]   X_LIM    = (POS_W+1)'(X_MAX);
    localparam logic signed [POS_W:0]   Y_LIM    = (POS_W+1)'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_APPLY = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       heading_q, heading_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [POS_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [2:0]       hd_pend_q, hd_pend_d;
    logic             blk_pend_q, blk_pend_d;
    logic             en_q, en_d;
    logic             blocked_q, blocked_d;
    logic             map_req_q, map_req_d;

    logic rot_l, rot_r, mv_f, mv_b;
    assign rot_l = (rotate_sig == 2'b10);
    assign rot_r = (rotate_sig == 2'b01);
    assign mv_f  = (move_sig == 2'b10);
    assign mv_b  = (move_sig == 2'b01);

    logic signed [1:0]     dx, dy, sx, sy;
    logic signed [POS_W:0] tx, ty;
    logic                  oob;

    always_comb begin
        dx = 2'sd0;
        dy = 2'sd0;
        case (heading_q)
            3'd0:    begin dx =  2'sd1; dy =  2'sd0; end
            3'd1:    begin dx =  2'sd1; dy =  2'sd1; end
            3'd2:    begin dx =  2'sd0; dy =  2'sd1; end
            3'd3:    begin dx = -2'sd1; dy =  2'sd1; end
            3'd4:    begin dx = -2'sd1; dy =  2'sd0; end
            3'd5:    begin dx = -2'sd1; dy = -2'sd1; end
            3'd6:    begin dx =  2'sd0; dy = -2'sd1; end
            default: begin dx =  2'sd1; dy = -2'sd1; end
        endcase
        sx  = mv_b ? -dx : dx;
        sy  = mv_b ? -dy : dy;
        // Any wrap at the edge of the signed range lands negative, so it still reads as out of bounds.
        tx  = $signed({1'b0, pos_x_q}) + $signed({{(POS_W-1){sx[1]}}, sx});
        ty  = $signed({1'b0, pos_y_q}) + $signed({{(POS_W-1){sy[1]}}, sy});
        oob = (tx < 0) || (tx > X_LIM) || (ty < 0) || (ty > Y_LIM);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        heading_d  = heading_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        hd_pend_d  = hd_pend_q;
        blk_pend_d = blk_pend_q;
        blocked_d  = 1'b0;
        map_req_d  = map_req_q;
        case (state_q)
            S_IDLE: begin
                if (rot_l || rot_r) begin
                    hd_pend_d  = rot_l ? heading_q + 3'd1 : heading_q - 3'd1;
                    tgt_x_d    = pos_x_q;
                    tgt_y_d    = pos_y_q;
                    blk_pend_d = 1'b0;
                    state_d    = S_APPLY;
                end else if (mv_f || mv_b) begin
                    hd_pend_d  = heading_q;
                    tgt_x_d    = tx[POS_W-1:0];
                    tgt_y_d    = ty[POS_W-1:0];
                    blk_pend_d = oob;
`ifdef WALL_CHECK_EN
                    if (oob) begin
                        state_d = S_APPLY;
                    end else begin
                        state_d   = S_CHECK;
                        map_req_d = 1'b1;
                    end
`else
                    state_d    = S_APPLY;
`endif
                end
            end
            S_CHECK: begin
`ifdef WALL_CHECK_EN
                if (map_ack) begin
                    map_req_d  = 1'b0;
                    blk_pend_d = map_wall;
                    state_d    = S_APPLY;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_APPLY: begin
                heading_d = hd_pend_q;
                if (!blk_pend_q) begin
                    pos_x_d = tgt_x_q;
                    pos_y_d = tgt_y_q;
                end
                blocked_d = blk_pend_q;
                cnt_d     = CNT_LOAD;
                state_d   = S_COOL;
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        en_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            heading_q  <= 3'd0;
            pos_x_q    <= POS_W'(START_X);
            pos_y_q    <= POS_W'(START_Y);
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            hd_pend_q  <= 3'd0;
            blk_pend_q <= 1'b0;
            en_q       <= 1'b0;
            blocked_q  <= 1'b0;
            map_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            heading_q  <= heading_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            hd_pend_q  <= hd_pend_d;
            blk_pend_q <= blk_pend_d;
            en_q       <= en_d;
            blocked_q  <= blocked_d;
            map_req_q  <= map_req_d;
        end
    end

    assign en_left     = en_q;
    assign en_right    = en_q;
    assign en_forward  = en_q;
    assign en_backward = en_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign heading     = heading_q;
    assign busy        = (state_q != S_IDLE);
    assign blocked     = blocked_q;

`ifdef WALL_CHECK_EN
    assign map_req = map_req_q;
    assign map_x   = tgt_x_q;
    assign map_y   = tgt_y_q;
`else
    logic unused_map;
    assign unused_map = map_ack ^ map_wall ^ map_req_q;
    assign map_req    = 1'b0;
    assign map_x      = '0;
    assign map_y      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motion_executor.sv
`default_nettype none
// ============================================================================
// tb_motion_executor : table-driven directed bench for motion_executor.
// Revision           : 1.0
// ============================================================================
module tb_motion_executor;
    localparam int POS_W    = 8;
    localparam int X_MAX    = 12;
    localparam int Y_MAX    = 12;
    localparam int START_X  = 10;
    localparam int START_Y  = 10;
    localparam int COOLDOWN = 4;
    localparam int NVEC     = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       rotate_sig = 2'b00;
    logic [1:0]       move_sig = 2'b00;
    logic             en_left, en_right, en_forward, en_backward;
    logic [POS_W-1:0] pos_x, pos_y, map_x, map_y;
    logic [2:0]       heading;
    logic             busy, blocked, map_req;
    logic             map_ack = 1'b0;
    logic             map_wall = 1'b0;

    motion_executor #(
        .POS_W(POS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .START_X(START_X), .START_Y(START_Y), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rst(rst), .rotate_sig(rotate_sig), .move_sig(move_sig),
        .en_left(en_left), .en_right(en_right), .en_forward(en_forward),
        .en_backward(en_backward), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .busy(busy), .blocked(blocked), .map_req(map_req), .map_x(map_x),
        .map_y(map_y), .map_ack(map_ack), .map_wall(map_wall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!en_left && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'd0, en_left}, 32'd1);
    endtask

    // Pulse one request and return at the negedge after the apply edge.
    task automatic send(input logic [1:0] rot, input logic [1:0] mv, output logic busy_e0);
        wait_idle();
        rotate_sig = rot;
        move_sig   = mv;
        @(posedge clk);
        @(negedge clk);
        rotate_sig = 2'b00;
        move_sig   = 2'b00;
        busy_e0    = busy;
`ifdef WALL_CHECK_EN
        if (map_req) begin
            map_wall = 1'b0;
            map_ack  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            map_ack  = 1'b0;
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] rot;
        logic [1:0] mv;
        logic [2:0] hd;
        int         x;
        int         y;
        logic       blk;
        logic       bsy;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic b;
        int   lows, rises;
        logic prev_busy;

        vecs[0]  = '{2'b10, 2'b00, 3'd1, 10, 10, 1'b0, 1'b1};
        vecs[1]  = '{2'b01, 2'b00, 3'd0, 10, 10, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 2'b00, 3'd7, 10, 10, 1'b0, 1'b1};
        vecs[3]  = '{2'b01, 2'b00, 3'd6, 10, 10, 1'b0, 1'b1};
        vecs[4]  = '{2'b10, 2'b00, 3'd7, 10, 10, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 2'b00, 3'd0, 10, 10, 1'b0, 1'b1};
        vecs[6]  = '{2'b00, 2'b10, 3'd0, 11, 10, 1'b0, 1'b1};
        vecs[7]  = '{2'b00, 2'b10, 3'd0, 12, 10, 1'b0, 1'b1};
        vecs[8]  = '{2'b00, 2'b10, 3'd0, 12, 10, 1'b1, 1'b1};
        vecs[9]  = '{2'b00, 2'b01, 3'd0, 11, 10, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 2'b10, 3'd1, 11, 10, 1'b0, 1'b1};
        vecs[11] = '{2'b00, 2'b10, 3'd1, 12, 11, 1'b0, 1'b1};
        vecs[12] = '{2'b00, 2'b01, 3'd1, 11, 10, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 2'b00, 3'd1, 11, 10, 1'b0, 1'b0};
        vecs[14] = '{2'b00, 2'b11, 3'd1, 11, 10, 1'b0, 1'b0};
        vecs[15] = '{2'b10, 2'b00, 3'd2, 11, 10, 1'b0, 1'b1};
        vecs[16] = '{2'b00, 2'b10, 3'd2, 11, 11, 1'b0, 1'b1};
        vecs[17] = '{2'b00, 2'b10, 3'd2, 11, 12, 1'b0, 1'b1};
        vecs[18] = '{2'b00, 2'b10, 3'd2, 11, 12, 1'b1, 1'b1};
        vecs[19] = '{2'b10, 2'b00, 3'd3, 11, 12, 1'b0, 1'b1};
        vecs[20] = '{2'b00, 2'b10, 3'd3, 11, 12, 1'b1, 1'b1};
        vecs[21] = '{2'b00, 2'b01, 3'd3, 12, 11, 1'b0, 1'b1};
        vecs[22] = '{2'b00, 2'b01, 3'd3, 12, 11, 1'b1, 1'b1};
        vecs[23] = '{2'b10, 2'b00, 3'd4, 12, 11, 1'b0, 1'b1};
        vecs[24] = '{2'b00, 2'b10, 3'd4, 11, 11, 1'b0, 1'b1};
        vecs[25] = '{2'b10, 2'b00, 3'd5, 11, 11, 1'b0, 1'b1};
        vecs[26] = '{2'b00, 2'b10, 3'd5, 10, 10, 1'b0, 1'b1};
        vecs[27] = '{2'b10, 2'b00, 3'd6, 10, 10, 1'b0, 1'b1};
        vecs[28] = '{2'b00, 2'b10, 3'd6, 10,  9, 1'b0, 1'b1};
        vecs[29] = '{2'b10, 2'b00, 3'd7, 10,  9, 1'b0, 1'b1};
        vecs[30] = '{2'b00, 2'b10, 3'd7, 11,  8, 1'b0, 1'b1};
        vecs[31] = '{2'b01, 2'b00, 3'd6, 11,  8, 1'b0, 1'b1};

        // Reset state, then release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", {28'd0, en_left, en_right, en_forward, en_backward}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_blocked", {31'd0, blocked}, 32'd0);
        chk("rst_map_req", {31'd0, map_req}, 32'd0);
        chk("rst_pos_x", 32'(pos_x), START_X);
        chk("rst_pos_y", 32'(pos_y), START_Y);
        chk("rst_heading", 32'(heading), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_en_before_edge", {31'd0, en_left}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_en_after_edge", {28'd0, en_left, en_right, en_forward, en_backward}, 32'hF);

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].rot, vecs[i].mv, b);
            chk($sformatf("v%0d_busy", i), {31'd0, b}, {31'd0, vecs[i].bsy});
            chk($sformatf("v%0d_heading", i), 32'(heading), 32'(vecs[i].hd));
            chk($sformatf("v%0d_pos_x", i), 32'(pos_x), vecs[i].x);
            chk($sformatf("v%0d_pos_y", i), 32'(pos_y), vecs[i].y);
            chk($sformatf("v%0d_blocked", i), {31'd0, blocked}, {31'd0, vecs[i].blk});
        end
`ifndef WALL_CHECK_EN
        chk("map_req_tied", {31'd0, map_req}, 32'd0);
        chk("map_xy_tied", {16'd0, map_x, map_y}, 32'd0);
`endif

        // Heading 6 from (11,8): walk down to y=0, then one more is blocked.
        for (int k = 0; k < 8; k++) send(2'b00, 2'b10, b);
        chk("ylow_pos_x", 32'(pos_x), 32'd11);
        chk("ylow_pos_y", 32'(pos_y), 32'd0);
        send(2'b00, 2'b10, b);
        chk("ylow_blocked", {31'd0, blocked}, 32'd1);
        chk("ylow_pos_y_held", 32'(pos_y), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("blocked_one_cycle", {31'd0, blocked}, 32'd0);

        // Turn to heading 4 and walk to x=0, then one more is blocked.
        send(2'b01, 2'b00, b);
        send(2'b01, 2'b00, b);
        chk("h4_heading", 32'(heading), 32'd4);
        for (int k = 0; k < 11; k++) send(2'b00, 2'b10, b);
        chk("xlow_pos_x", 32'(pos_x), 32'd0);
        send(2'b00, 2'b10, b);
        chk("xlow_blocked", {31'd0, blocked}, 32'd1);
        chk("xlow_pos_x_held", 32'(pos_x), 32'd0);

        // Enables stay low COOLDOWN+1 cycles; a stale request during busy is ignored.
        wait_idle();
        rotate_sig = 2'b10;
        @(posedge clk);
        @(negedge clk);
        lows = 0;
        for (int k = 0; k < 20 && !en_left; k++) begin
            lows++;
            @(posedge clk);
            @(negedge clk);
            rotate_sig = 2'b00;
        end
        rotate_sig = 2'b00;
        chk("cooldown_low_cycles", 32'(lows), COOLDOWN + 1);
        chk("stale_ignored_heading", 32'(heading), 32'd5);

        // Held request: one accept every COOLDOWN+2 cycles.
        wait_idle();
        rotate_sig = 2'b10;
        rises = 0;
        prev_busy = 1'b0;
        for (int k = 0; k < 2 * (COOLDOWN + 2); k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        rotate_sig = 2'b00;
        chk("held_accepts", 32'(rises), 32'd2);
        chk("held_heading", 32'(heading), 32'd7);

        // Asynchronous reset in the middle of a cooldown.
        wait_idle();
        rotate_sig = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rotate_sig = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("pre_abort_heading", 32'(heading), 32'd6);
        #2 rst = 1'b0;
        #1;
        chk("abort_heading", 32'(heading), 32'd0);
        chk("abort_pos", {16'd0, pos_x, pos_y}, {16'd0, 8'(START_X), 8'(START_Y)});
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_en", {31'd0, en_left}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef WALL_CHECK_EN
        send(2'b10, 2'b00, b);
        send(2'b10, 2'b00, b);
        chk("wc_heading", 32'(heading), 32'd2);
        for (int w = 1; w >= 0; w--) begin
            wait_idle();
            move_sig = 2'b10;
            @(posedge clk);
            @(negedge clk);
            move_sig = 2'b00;
            chk("wc_req", {31'd0, map_req}, 32'd1);
            chk("wc_xy", {16'd0, map_x, map_y}, {16'd0, 8'd10, 8'd11});
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk("wc_req_held", {31'd0, map_req}, 32'd1);
                chk("wc_xy_held", {16'd0, map_x, map_y}, {16'd0, 8'd10, 8'd11});
                chk("wc_pos_wait", 32'(pos_y), 32'd10);
            end
            map_wall = w[0];
            map_ack  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            map_ack  = 1'b0;
            map_wall = 1'b0;
            chk("wc_req_drop", {31'd0, map_req}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("wc_blocked", {31'd0, blocked}, {31'd0, w[0]});
            chk("wc_pos_y", 32'(pos_y), (w == 1) ? 32'd10 : 32'd11);
        end
        wait_idle();
        move_sig = 2'b10;
        @(posedge clk);
        @(negedge clk);
        move_sig = 2'b00;
        chk("wc_req_before_abort", {31'd0, map_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("wc_abort_req", {31'd0, map_req}, 32'd0);
        chk("wc_abort_pos_y", 32'(pos_y), START_Y);
        @(negedge clk);
        rst = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motion_executor.md
# motion_executor

Consumer side of the tracer's key-control path. Accepts the registered rotate/move request pulses produced by the key-control host and applies them to the viewer state: an 8-way heading plus an X/Y grid position. Generates the per-direction enables the host uses to gate those requests, which rate-limits auto-repeat while a key is held. Position and heading feed the ray-cast/render pipeline.

## Interface
- POS_W, 8: position width, unsigned
- X_MAX, 255: largest legal pos_x
- Y_MAX, 255: largest legal pos_y
- START_X, 0: pos_x reset value
- START_Y, 0: pos_y reset value
- COOLDOWN, 16: cooldown cycles after each accepted request, ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rotate_sig  in  2  [1]=left, [0]=right request
- move_sig  in  2  [1]=forward, [0]=backward request
- en_left, en_right, en_forward, en_backward  out  1 each  request enables to host
- pos_x, pos_y  out  POS_W each  current position
- heading  out  3  0..7, 45° steps
- busy  out  1  state ≠ IDLE
- blocked  out  1  one-cycle pulse: last move rejected
- map_req  out  1  wall query valid (WALL_CHECK_EN only, else tied 0)
- map_x, map_y  out  POS_W each  queried cell
- map_ack  in  1  query answered; map_wall valid this cycle
- map_wall  in  1  1 = cell is a wall

## Operation
- States: IDLE, CHECK (WALL_CHECK_EN only), APPLY, COOLDOWN.
- Requests sampled only in IDLE; ignored in every other state.
- Decode in IDLE: rotate_sig=10 → left; 01 → right; 11/00 → no rotation. move_sig=10 → forward; 01 → backward; 11/00 → no move. Valid rotation beats simultaneous valid move; the move is dropped, not queued.
- Left: heading+1 mod 8. Right: heading−1 mod 8 (7→0, 0→7 wrap).
- Step vector (dx,dy) by heading 0..7: (+1,0) (+1,+1) (0,+1) (−1,+1) (−1,0) (−1,−1) (0,−1) (+1,−1). Backward uses negated vector.
- Target computed at POS_W+1 signed width; out of bounds if <0 or >X_MAX / >Y_MAX on either axis.
- IDLE + rotation → APPLY (heading updated) → COOLDOWN.
- IDLE + move, out of bounds → APPLY with position unchanged, blocked=1 → COOLDOWN.
- IDLE + move, in bounds → CHECK (if compiled) else APPLY (position ← target) → COOLDOWN.
- COOLDOWN: counter loaded COOLDOWN−1, decrements each cycle; at 0 → IDLE.
- en_* registered; all four are 1 exactly when state=IDLE, 0 otherwise.

## Timing
- Reset: state IDLE, pos=START_X/START_Y, heading 0, en_* 0, busy 0, blocked 0, map_req 0, cooldown counter 0. en_* rise at first clk edge after rst deasserts.
- Accept at edge E0 → busy=1, en_*=0 after E0; heading/pos update and blocked pulse at E1; IDLE and en_*=1 at E(COOLDOWN+1). Without CHECK, en_* low for COOLDOWN+1 cycles.
- Host emits a request one cycle after seeing an enable, so one stale request may arrive while busy; it is ignored.
- CHECK: map_req, map_x, map_y registered, asserted at E0, held stable until map_ack sampled high; then APPLY. map_wall=1 → position unchanged, blocked=1. map_ack while map_req=0 ignored. No timeout.
- Reset mid-operation: immediate abort to reset values, map_req drops asynchronously.

## Configuration
- WALL_CHECK_EN defined: CHECK state and map_* handshake present; in-bounds moves wait on map_ack.
- Undefined: no CHECK state, map_req tied 0, map_x/map_y tied 0, map_ack/map_wall unused; only bounds checking applies.

## Test plan
- Reset release, START=(10,10): en_* 0 during reset, 1 one edge after; pos (10,10), heading 0.
- rotate_sig=10 one cycle, COOLDOWN=4: heading 0→1 at E1, en_* low 5 cycles; rotate_sig=01 twice at heading 0 → 7, then 6.
- Heading 0, pos (X_MAX,5), move_sig=10: blocked pulse, pos unchanged; move_sig=01 → pos (X_MAX−1,5).
- rotate_sig=10 and move_sig=10 same cycle: heading +1, position unchanged; rotate_sig=11 → no change, no busy.
- WALL_CHECK_EN, heading 2, pos (3,3), forward: map_req with (3,4) held 3 cycles until map_ack; map_wall=1 → blocked, pos (3,3); map_wall=0 → pos (3,4).
- Request held continuously, COOLDOWN=2: one step per 4 cycles (3 busy + 1 idle accept); rst low mid-CHECK → map_req 0 immediately, pos back to START.
